// File: rtl/bus_rr_xbar.sv
// Multi-host shared bus: arbitrates hosts, decodes address per device, registered response.
// Define BUS_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (lowest host wins).
module bus_rr_xbar #(
   parameter int unsigned NrHosts      = 2,
   parameter int unsigned NrDevices    = 2,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned AddressWidth = 32
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NrHosts-1:0]                host_req_i,
   output logic [NrHosts-1:0]                host_gnt_o,
   input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
   input  logic [NrHosts-1:0]                host_we_i,
   input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
   output logic [NrHosts-1:0]                host_rvalid_o,
   output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
   output logic [NrHosts-1:0]                host_err_o,
   output logic [NrDevices-1:0]              device_req_o,
   output logic [NrDevices*AddressWidth-1:0] device_addr_o,
   output logic [NrDevices-1:0]              device_we_o,
   output logic [NrDevices*DataWidth-1:0]    device_wdata_o,
   input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
   input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base,
   input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask
);
   localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

   logic [AddressWidth-1:0] h_addr  [NrHosts];
   logic [DataWidth-1:0]    h_wdata [NrHosts];
   logic [DataWidth-1:0]    d_rdata [NrDevices];
   logic [AddressWidth-1:0] d_base  [NrDevices];
   logic [AddressWidth-1:0] d_mask  [NrDevices];

   for (genvar h = 0; h < NrHosts; h++) begin : g_host
      assign h_addr[h]  = host_addr_i[h*AddressWidth +: AddressWidth];
      assign h_wdata[h] = host_wdata_i[h*DataWidth +: DataWidth];
   end

   for (genvar d = 0; d < NrDevices; d++) begin : g_dev
      assign d_rdata[d] = device_rdata_i[d*DataWidth +: DataWidth];
      assign d_base[d]  = cfg_device_addr_base[d*AddressWidth +: AddressWidth];
      assign d_mask[d]  = cfg_device_addr_mask[d*AddressWidth +: AddressWidth];
   end

   logic                gnt_valid;
   logic [HostIdxW-1:0] gnt_idx;
`ifdef BUS_RR_ARB_EN
   logic [HostIdxW-1:0] rr_ptr_q;
`endif

   always_comb begin : arb
      int unsigned         cand;
      logic [HostIdxW-1:0] cand_idx;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned i = 0; i < NrHosts; i++) begin
`ifdef BUS_RR_ARB_EN
         cand = 32'(rr_ptr_q) + i;
         if (cand >= NrHosts) cand = cand - NrHosts;
`else
         cand = i;
`endif
         cand_idx = HostIdxW'(cand);
         if (!gnt_valid && host_req_i[cand_idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand_idx;
         end
      end
      // Nothing is granted while reset is held so every output stays quiet.
      if (rst_i) gnt_valid = 1'b0;
   end

   logic [AddressWidth-1:0] g_addr;
   logic [DataWidth-1:0]    g_wdata;
   logic                    g_we;

   assign g_addr  = gnt_valid ? h_addr[gnt_idx]  : '0;
   assign g_wdata = gnt_valid ? h_wdata[gnt_idx] : '0;
   assign g_we    = gnt_valid ? host_we_i[gnt_idx] : 1'b0;

   logic               dev_hit;
   logic [DevIdxW-1:0] dev_idx;

   always_comb begin
      dev_hit = 1'b0;
      dev_idx = '0;
      for (int unsigned d = 0; d < NrDevices; d++) begin
         if (!dev_hit && ((g_addr & d_mask[d]) == d_base[d])) begin
            dev_hit = 1'b1;
            dev_idx = DevIdxW'(d);
         end
      end
   end

   always_comb begin
      host_gnt_o   = '0;
      device_req_o = '0;
      for (int unsigned h = 0; h < NrHosts; h++) begin
         host_gnt_o[h] = gnt_valid && (gnt_idx == HostIdxW'(h));
      end
      for (int unsigned d = 0; d < NrDevices; d++) begin
         device_req_o[d] = gnt_valid && dev_hit && (dev_idx == DevIdxW'(d));
      end
   end

   assign device_addr_o  = {NrDevices{g_addr}};
   assign device_wdata_o = {NrDevices{g_wdata}};
   assign device_we_o    = {NrDevices{g_we}};

   logic                rsp_valid_q;
   logic                rsp_we_q;
   logic                rsp_err_q;
   logic [HostIdxW-1:0] rsp_host_q;
   logic [DevIdxW-1:0]  rsp_dev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_host_q  <= '0;
         rsp_dev_q   <= '0;
`ifdef BUS_RR_ARB_EN
         rr_ptr_q    <= '0;
`endif
      end else begin
         rsp_valid_q <= gnt_valid;
         rsp_we_q    <= g_we;
         rsp_err_q   <= gnt_valid && !dev_hit;
         rsp_host_q  <= gnt_idx;
         rsp_dev_q   <= dev_idx;
`ifdef BUS_RR_ARB_EN
         if (gnt_valid) begin
            rr_ptr_q <= (32'(gnt_idx) == NrHosts - 1) ? '0 : gnt_idx + 1'b1;
         end
`endif
      end
   end

   always_comb begin
      host_rvalid_o = '0;
      host_rdata_o  = '0;
      host_err_o    = '0;
      for (int unsigned h = 0; h < NrHosts; h++) begin
         if (rsp_valid_q && !rst_i && (rsp_host_q == HostIdxW'(h))) begin
            host_rvalid_o[h] = 1'b1;
            host_err_o[h]    = rsp_err_q;
            if (!rsp_we_q && !rsp_err_q) begin
               host_rdata_o[h*DataWidth +: DataWidth] = d_rdata[rsp_dev_q];
            end
         end
      end
   end
endmodule
